sys_timer_ctrl: RTL and testbench
=================================

# sys_timer_ctrl

Memory-mapped controller for the core's system timer. Holds the 64-bit `mtimecmp` compare value and the control/status registers, compares against the free-running 64-bit `time` count supplied by the system timer, and drives the machine timer interrupt line. Sits between the data-memory bus, through a single-outstanding valid/ready port, and the core's interrupt input. It also gives bus masters a tear-free 64-bit `mtime` read via a high-word snapshot.

## Interface
- `ADDR_W`, default 5: byte-address width of the register window.
- `CNT_W`, default 8: width of the saturating fire counter (≤ 16).
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `time_lo` in 32: current `time[31:0]` from the system timer.
- `time_hi` in 32: current `time[63:32]` from the system timer.
- `req_valid` in 1: bus request valid.
- `req_ready` out 1: controller can accept a request.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in `ADDR_W`: byte address.
- `req_wdata` in 32: write data.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: master accepts response.
- `rsp_rdata` out 32: read data; 0 for writes and errors.
- `rsp_err` out 1: unmapped or misaligned access.
- `mtip` out 1: machine timer interrupt pending, level.

## Operation
- Register map (word-aligned):
  - 0x00 `CMP_LO`: R/W.
  - 0x04 `CMP_HI`: R/W.
  - 0x08 `CTRL`: R/W. bit0 `en`; other bits read 0, writes ignored.
  - 0x0C `STATUS`: bit0 raw compare result; bits[8+CNT_W-1:8] fire count. Any write clears the count.
  - 0x10 `MTIME_LO`: RO. Returns live `time_lo` and latches `time_hi` into `snap_hi`.
  - 0x14 `MTIME_HI`: RO. Returns `snap_hi`.
- Error cases, all giving `rsp_err`=1, `rsp_rdata`=0, no side effect:
  - `req_addr[1:0]`≠0.
  - Address > 0x14.
  - Writes to 0x10 or 0x14.
- Reset values:
  - `CMP` = 64'hFFFF_FFFF_FFFF_FFFF.
  - `en` = 0, fire count = 0, `snap_hi` = 0.
  - `mtip` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0, `req_ready` = 1.
- Handshake FSM, two states:
  - IDLE: `req_ready`=1. On `req_valid`, the access is performed at that edge and the FSM moves to RESP.
  - RESP: `req_ready`=0. `rsp_valid`=1; `rsp_rdata` and `rsp_err` are held stable. When `rsp_valid && rsp_ready`, return to IDLE.
  - No back-to-back acceptance: at most one request per two cycles.
- Compare:
  - `hit` = unsigned 64-bit `{time_hi,time_lo} >= CMP`, evaluated every cycle.
  - `mtip` is registered: `mtip <= en & hit`.
- Fire count:
  - Increments on a 0→1 transition of registered `en & hit`.
  - Saturates at 2^CNT_W−1.
  - If a STATUS write and an increment coincide, the clear wins.
- 64-bit update rule: CMP halves are written independently. Software writes `CMP_HI` = all-ones first to avoid a spurious `mtip`. Hardware adds no interlock.

## Timing
- Request accepted at edge N → `rsp_valid`=1 from N+1 until the edge where `rsp_ready`=1.
- A register write takes effect at edge N. `mtip` reflects the new CMP or `en` at edge N+1, i.e. visible in cycle N+1 after the update.
- `time` change at edge T → `mtip` updated at edge T+1.
- `MTIME_LO` read: `snap_hi` is latched at the acceptance edge, from the same-cycle `time_hi`.
- Wrap-around: when `time` wraps from all-ones to 0, `hit` deasserts unless CMP = 0. CMP = 0 with `en`=1 keeps `mtip`=1 permanently.
- Asynchronous reset during RESP: `rsp_valid` drops to 0 immediately. The pending response is discarded and the FSM returns to IDLE.
- `rsp_ready` held high in IDLE has no effect.

## Test plan
- Reset defaults: assert reset, then read CTRL → 0; read `CMP_LO` → 0xFFFFFFFF; `mtip`=0; `req_ready`=1.
- Compare fire: write `CMP_HI`=0, `CMP_LO`=0x20, CTRL=1. Ramp `time` 0x1E→0x21 → `mtip` rises the cycle after `time`=0x20. STATUS reads 0x101.
- 64-bit tear-free read: `time`=0x0000_0001_FFFF_FFFF. Read `MTIME_LO`, step `time` to 0x2_0000_0000, read `MTIME_HI` → returns 0xFFFFFFFF then 0x1.
- Handshake backpressure: read `CMP_LO` while `rsp_ready`=0 for 5 cycles → `rsp_valid`/`rsp_rdata` stable, `req_ready`=0. Issue a new `req_valid` meanwhile → not accepted.
- Errors: write 0x10, read 0x02, read 0x18 → each gives `rsp_err`=1 and `rsp_rdata`=0, with registers unchanged.
- Saturation and clear: with CNT_W=2, toggle `en` 5× while `hit` is true → count reads 3. A STATUS write coinciding with a rise → count 0. Reset asserted mid-RESP → `rsp_valid`=0 at once.

Source files
------------

// File: rtl/sys_timer_ctrl.sv
// rtl/sys_timer_ctrl.sv - machine timer compare/interrupt controller behind a single-outstanding register port
// Holds mtimecmp, enable and fire count; drives mtip and serves a tear-free mtime read via a high-word snapshot.
module sys_timer_ctrl #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       time_lo,
  input  logic [31:0]       time_hi,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mtip
);

  localparam logic [ADDR_W-1:0] A_CMP_LO   = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] A_CMP_HI   = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] A_CTRL     = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(32'h0C);
  localparam logic [ADDR_W-1:0] A_MTIME_LO = ADDR_W'(32'h10);
  localparam logic [ADDR_W-1:0] A_MTIME_HI = ADDR_W'(32'h14);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  typedef enum logic {S_IDLE = 1'b0, S_RESP = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [31:0]       r_cmp_lo;
  logic [31:0]       r_cmp_hi;
  logic              r_en;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_snap_hi;
  logic              r_mtip;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic              w_hit;
  logic              w_fire;
  logic              w_rise;
  logic              w_accept;
  logic              w_bad;
  logic              w_wr;
  logic              w_clr;
  logic              w_snap;
  logic [31:0]       w_status;
  logic [31:0]       w_rdata;

  assign w_hit  = {time_hi, time_lo} >= {r_cmp_hi, r_cmp_lo};
  assign w_fire = r_en & w_hit;
  // The count tracks the edge at which mtip itself goes high.
  assign w_rise = w_fire & ~r_mtip;

  assign w_accept = (r_state == S_IDLE) && req_valid;
  assign w_bad    = (req_addr[1:0] != 2'b00) || (req_addr > A_MTIME_HI) ||
                    (req_we && ((req_addr == A_MTIME_LO) || (req_addr == A_MTIME_HI)));
  assign w_wr     = w_accept && req_we && !w_bad;
  assign w_clr    = w_wr && (req_addr == A_STATUS);
  assign w_snap   = w_accept && !req_we && !w_bad && (req_addr == A_MTIME_LO);

  always_comb begin
    w_status              = '0;
    w_status[8 +: CNT_W]  = r_cnt;
    w_status[0]           = w_hit;
  end

  always_comb begin
    w_rdata = '0;
    if (!req_we && !w_bad) begin
      case (req_addr)
        A_CMP_LO:   w_rdata = r_cmp_lo;
        A_CMP_HI:   w_rdata = r_cmp_hi;
        A_CTRL:     w_rdata = {31'b0, r_en};
        A_STATUS:   w_rdata = w_status;
        A_MTIME_LO: w_rdata = time_lo;
        A_MTIME_HI: w_rdata = r_snap_hi;
        default:    w_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_state_next = S_RESP;
      S_RESP:  if (rsp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == S_IDLE);
    rsp_valid = (r_state == S_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_rdata <= w_rdata;
      r_err   <= w_bad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmp_lo  <= '1;
      r_cmp_hi  <= '1;
      r_en      <= 1'b0;
      r_snap_hi <= '0;
    end else begin
      if (w_wr && (req_addr == A_CMP_LO)) r_cmp_lo <= req_wdata;
      if (w_wr && (req_addr == A_CMP_HI)) r_cmp_hi <= req_wdata;
      if (w_wr && (req_addr == A_CTRL))   r_en     <= req_wdata[0];
      if (w_snap)                         r_snap_hi <= time_hi;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtip <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_mtip <= w_fire;
      if (w_clr) begin
        r_cnt <= '0;
      end else if (w_rise && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign mtip      = r_mtip;

endmodule

// File: tb/tb_sys_timer_ctrl.sv
// tb/tb_sys_timer_ctrl.sv - self-checking bench for sys_timer_ctrl against a register-level reference model
module tb_sys_timer_ctrl;
  localparam int ADDR_W  = 5;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       time_lo = '0;
  logic [31:0]       time_hi = '0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mtip;

  int checks = 0;
  int failures = 0;

  logic [63:0] m_cmp;
  bit          m_en;
  int          m_cnt;
  logic [31:0] m_snap;
  bit          m_mtip;
  bit          m_idle;
  logic [31:0] m_exp_rdata;
  bit          m_exp_err;

  sys_timer_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .time_lo(time_lo), .time_hi(time_hi),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mtip(mtip)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_cmp = '1; m_en = 0; m_cnt = 0; m_snap = '0; m_mtip = 0; m_idle = 1;
  endfunction

  // Applies the register-map rules for one clock edge using pre-edge inputs.
  function automatic void model_step();
    logic [63:0] t;
    bit hit, fire, clr, bad;
    int a;
    t = {time_hi, time_lo};
    hit = (t >= m_cmp);
    fire = m_en && hit;
    clr = 0;
    if (m_idle) begin
      if (req_valid) begin
        a = int'(req_addr);
        bad = (a % 4 != 0) || (a > 20) || (req_we && a >= 16);
        m_exp_err = bad;
        m_exp_rdata = '0;
        if (!bad) begin
          if (req_we) begin
            case (a)
              0:  m_cmp[31:0] = req_wdata;
              4:  m_cmp[63:32] = req_wdata;
              8:  m_en = req_wdata[0];
              12: clr = 1;
              default: ;
            endcase
          end else begin
            case (a)
              0:  m_exp_rdata = m_cmp[31:0];
              4:  m_exp_rdata = m_cmp[63:32];
              8:  m_exp_rdata = {31'b0, m_en};
              12: m_exp_rdata = (m_cnt * 256) + (hit ? 1 : 0);
              16: begin m_exp_rdata = time_lo; m_snap = time_hi; end
              20: m_exp_rdata = m_snap;
              default: ;
            endcase
          end
        end
        m_idle = 0;
      end
    end else if (rsp_ready) begin
      m_idle = 1;
    end
    if (clr) m_cnt = 0;
    else if (fire && !m_mtip && m_cnt < CNT_MAX) m_cnt++;
    m_mtip = fire;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic bus(input bit we, input logic [ADDR_W-1:0] addr, input logic [31:0] wd,
                     input int hold, output logic [31:0] rd, output logic er, output bit ok);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd; rsp_ready = 0;
    tick();
    req_valid = 0;
    ok = (rsp_valid === 1'b1) && (req_ready === 1'b0);
    for (int i = 0; i < hold; i++) begin
      tick();
      if (rsp_valid !== 1'b1) ok = 0;
    end
    rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) ok = 0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; bit ok;
    rst_n = 0;
    model_reset();
    tick(); tick();
    checks++;
    if (mtip !== 0 || req_ready !== 1 || rsp_valid !== 0 || rsp_rdata !== 0 || rsp_err !== 0) begin
      failures++;
      $display("FAIL reset_outputs got mtip=%b rdy=%b vld=%b rd=%h err=%b exp 0 1 0 0 0",
               mtip, req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    rst_n = 1;
    tick();
    bus(0, 5'h08, 0, 0, rd, er, ok);
    checks++;
    if (rd !== 32'h0 || er !== 0 || !ok) begin
      failures++; $display("FAIL reset_ctrl got=%h err=%b ok=%0d exp=0", rd, er, ok);
    end
    bus(0, 5'h00, 0, 0, rd, er, ok);
    checks++;
    if (rd !== 32'hFFFF_FFFF || rd !== m_exp_rdata || !ok) begin
      failures++; $display("FAIL reset_cmp_lo got=%h exp=ffffffff", rd);
    end
    bus(0, 5'h04, 0, 0, rd, er, ok);
    checks++;
    if (rd !== 32'hFFFF_FFFF || !ok) begin
      failures++; $display("FAIL reset_cmp_hi got=%h exp=ffffffff", rd);
    end
  endtask

  task automatic test_compare();
    logic [31:0] rd; logic er; bit ok;
    bus(1, 5'h04, 32'h0, 0, rd, er, ok);
    bus(1, 5'h00, 32'h20, 0, rd, er, ok);
    bus(1, 5'h08, 32'h1, 0, rd, er, ok);
    for (int t = 'h1E; t <= 'h21; t++) begin
      time_lo = t;
      checks++;
      if (mtip !== 1'b0 && t <= 'h20) begin
        failures++; $display("FAIL compare_pre t=%h got=%b exp=0", t, mtip);
      end
      tick();
      checks++;
      if (mtip !== (t >= 'h20) || mtip !== m_mtip) begin
        failures++; $display("FAIL compare_mtip t=%h got=%b exp=%b", t, mtip, t >= 'h20);
      end
    end
    bus(0, 5'h0C, 0, 0, rd, er, ok);
    checks++;
    if (rd !== 32'h101 || rd !== m_exp_rdata || er !== 0 || !ok) begin
      failures++; $display("FAIL compare_status got=%h exp=101", rd);
    end
  endtask

  task automatic test_tear_free();
    logic [31:0] rd; logic er; bit ok;
    time_hi = 32'h1; time_lo = 32'hFFFF_FFFF;
    bus(0, 5'h10, 0, 0, rd, er, ok);
    checks++;
    if (rd !== 32'hFFFF_FFFF || !ok) begin
      failures++; $display("FAIL mtime_lo got=%h exp=ffffffff", rd);
    end
    time_hi = 32'h2; time_lo = 32'h0;
    bus(0, 5'h14, 0, 1, rd, er, ok);
    checks++;
    if (rd !== 32'h1 || rd !== m_exp_rdata || !ok) begin
      failures++; $display("FAIL mtime_hi_snap got=%h exp=1", rd);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, rd0; logic er; bit ok;
    req_valid = 1; req_we = 0; req_addr = 5'h00; rsp_ready = 0;
    tick();
    rd0 = rsp_rdata;
    req_we = 1; req_addr = 5'h08; req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1 || req_ready !== 0 || rsp_rdata !== rd0 || rd0 !== 32'h20) begin
        failures++;
        $display("FAIL backpressure_hold cyc=%0d vld=%b rdy=%b rd=%h exp 1 0 00000020",
                 i, rsp_valid, req_ready, rsp_rdata);
      end
    end
    req_valid = 0; rsp_ready = 1;
    tick();
    rsp_ready = 0;
    checks++;
    if (rsp_valid !== 0 || req_ready !== 1) begin
      failures++; $display("FAIL backpressure_release vld=%b rdy=%b exp 0 1", rsp_valid, req_ready);
    end
    bus(0, 5'h08, 0, 0, rd, er, ok);
    checks++;
    if (rd !== 32'h1 || rd !== m_exp_rdata || !ok) begin
      failures++; $display("FAIL backpressure_ignored got ctrl=%h exp=1", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; bit ok;
    logic [ADDR_W-1:0] addrs [4] = '{5'h10, 5'h02, 5'h18, 5'h14};
    bit wes [4] = '{1, 0, 0, 1};
    for (int i = 0; i < 4; i++) begin
      bus(wes[i], addrs[i], 32'hDEAD_0000, 0, rd, er, ok);
      checks++;
      if (er !== 1 || rd !== 0 || !ok) begin
        failures++; $display("FAIL error_addr a=%h got err=%b rd=%h exp err=1 rd=0", addrs[i], er, rd);
      end
    end
    bus(0, 5'h00, 0, 0, rd, er, ok);
    checks++;
    if (rd !== 32'h20 || er !== 0) begin
      failures++; $display("FAIL error_no_side_effect got cmp_lo=%h exp=20", rd);
    end
  endtask

  task automatic test_saturation_clear();
    logic [31:0] rd; logic er; bit ok;
    time_hi = 0; time_lo = 0;
    bus(1, 5'h08, 32'h0, 0, rd, er, ok);
    bus(1, 5'h00, 32'h0, 0, rd, er, ok);
    bus(1, 5'h0C, 32'h0, 0, rd, er, ok);
    for (int i = 0; i < 5; i++) begin
      bus(1, 5'h08, 32'h1, 0, rd, er, ok);
      bus(1, 5'h08, 32'h0, 0, rd, er, ok);
    end
    bus(0, 5'h0C, 0, 0, rd, er, ok);
    checks++;
    if (rd !== 32'h301 || rd !== m_exp_rdata) begin
      failures++; $display("FAIL saturate_count got=%h exp=301", rd);
    end
    bus(1, 5'h00, 32'h100, 0, rd, er, ok);
    bus(1, 5'h08, 32'h1, 0, rd, er, ok);
    bus(1, 5'h0C, 32'h0, 0, rd, er, ok);
    time_lo = 32'h200;
    tick(); tick();
    time_lo = 32'h0;
    tick(); tick();
    time_lo = 32'h200;
    bus(1, 5'h0C, 32'h0, 0, rd, er, ok);
    checks++;
    if (mtip !== 1 || mtip !== m_mtip) begin
      failures++; $display("FAIL coincide_mtip got=%b exp=1", mtip);
    end
    bus(0, 5'h0C, 0, 0, rd, er, ok);
    checks++;
    if (rd !== 32'h001 || rd !== m_exp_rdata) begin
      failures++; $display("FAIL clear_wins got=%h exp=001", rd);
    end
  endtask

  task automatic test_reset_mid_resp();
    req_valid = 1; req_we = 0; req_addr = 5'h00; rsp_ready = 0;
    tick();
    req_valid = 0;
    #2;
    rst_n = 0;
    #1;
    model_reset();
    checks++;
    if (rsp_valid !== 0 || req_ready !== 1 || mtip !== 0) begin
      failures++; $display("FAIL reset_mid_resp vld=%b rdy=%b mtip=%b exp 0 1 0", rsp_valid, req_ready, mtip);
    end
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] rd, wd; logic er; bit ok;
    logic [ADDR_W-1:0] a;
    bit we;
    int hold, idle;
    bus(1, 5'h04, 32'h0, 0, rd, er, ok);
    for (int n = 0; n < 150; n++) begin
      time_hi = 0;
      time_lo = $urandom_range(0, 63);
      idle = $urandom_range(0, 2);
      for (int k = 0; k < idle; k++) begin
        tick();
        checks++;
        if (mtip !== m_mtip) begin
          failures++; $display("FAIL random_mtip n=%0d got=%b exp=%b", n, mtip, m_mtip);
        end
      end
      a = ADDR_W'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) a = {a[ADDR_W-1:2], 2'b00};
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      if (a == 5'h00) wd = $urandom_range(0, 63);
      if (a == 5'h04 && $urandom_range(0, 1) == 1) wd = 0;
      hold = $urandom_range(0, 3);
      bus(we, a, wd, hold, rd, er, ok);
      checks++;
      if (rd !== m_exp_rdata || er !== m_exp_err || !ok || mtip !== m_mtip) begin
        failures++;
        $display("FAIL random_bus n=%0d a=%h we=%b got rd=%h err=%b ok=%0d mtip=%b exp rd=%h err=%b mtip=%b",
                 n, a, we, rd, er, ok, mtip, m_exp_rdata, m_exp_err, m_mtip);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #1;
    test_reset();
    test_compare();
    test_tear_free();
    test_backpressure();
    test_errors();
    test_saturation_clear();
    test_reset_mid_resp();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
